// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, flag bit positions and FSM encoding shared by the ALU issuer
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NOTA = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_EQ   = 3'b111;

  localparam int FLG_C = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_V = 0;

  // Response word: result nibble above the three flag bits
  localparam int RSP_W = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/alu_issuer_if.sv
// rtl/alu_issuer_if.sv - request and response handshakes between a requester and the ALU issuer
interface alu_issuer_if;

  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic       req_use_acc;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic [2:0] rsp_flags;

  modport master (
    output req_valid, req_op, req_a, req_b, req_use_acc, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_flags
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_use_acc, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_flags
  );

endinterface

// File: rtl/alu_issuer_rsp_fifo.sv
// rtl/alu_issuer_rsp_fifo.sv - small power-of-two response FIFO with occupancy count
module rsp_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issuer.sv
// rtl/alu_issuer.sv - sequential initiator driving an external 4-bit ALU, with accumulator chaining
module alu_issuer
  import alu_pkg::*;
#(
  parameter int RSP_DEPTH = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issuer_if.slave      bus,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [3:0]       alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic [3:0]       acc,
  output logic [CNT_W-1:0] op_count
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      fifo_count;
  logic               has_space;
  logic               ready;
  logic               accept;
  logic               push;
  logic [RSP_W-1:0]   rsp_word;
  logic [RSP_W-1:0]   head;

  assign has_space = fifo_count < CW'(RSP_DEPTH);

  // Ready is gated by rst_n so it stays low while reset is held
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    accept    = 1'b0;
    push      = 1'b0;
    case (state)
      ST_IDLE: begin
        ready  = rst_n && has_space;
        accept = bus.req_valid && ready;
        if (accept) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        push      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rsp_word        = '0;
    rsp_word[6:3]   = alu_out;
    rsp_word[FLG_C] = alu_carry;
    rsp_word[FLG_Z] = alu_zero;
    rsp_word[FLG_V] = alu_ovf;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= OP_ADD;
      acc      <= '0;
      op_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_a  <= bus.req_use_acc ? acc : bus.req_a;
        alu_b  <= bus.req_b;
        alu_op <= bus.req_op;
      end
      if (push) begin
        acc      <= alu_out;
        op_count <= op_count + 1'b1;
      end
    end
  end

  rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (rsp_word),
    .pop       (bus.rsp_ready),
    .head      (head),
    .count     (fifo_count)
  );

  assign bus.req_ready = ready;
  assign bus.rsp_valid = fifo_count != '0;
  assign bus.rsp_data  = head[6:3];
  assign bus.rsp_flags = head[2:0];

endmodule

// File: tb/tb_alu_issuer.sv
// tb/tb_alu_issuer.sv - randomized and directed bench for alu_issuer against a queue-based reference
module tb_alu_issuer;
  import alu_pkg::*;

  localparam int RSP_DEPTH = 2;
  localparam int CNT_W     = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       alu_a, alu_b, alu_out, acc;
  logic [2:0]       alu_op;
  logic             alu_carry, alu_zero, alu_ovf;
  logic [CNT_W-1:0] op_count;

  always #5 clk = ~clk;

  alu_issuer_if bus ();

  alu_issuer #(.RSP_DEPTH(RSP_DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .alu_zero  (alu_zero),
    .alu_ovf   (alu_ovf),
    .acc       (acc),
    .op_count  (op_count)
  );

  // The 4-bit ALU lives in the bench; result word is {out, carry, zero, ovf}
  function automatic logic [6:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
    logic [4:0] s;
    logic       c;
    logic       v;
    s = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        c = s[4];
        v = (a[3] == b[3]) && (s[3] != a[3]);
      end
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        c = s[4];
        v = (a[3] != b[3]) && (s[3] != a[3]);
      end
      OP_NOTA: s = {1'b0, ~a};
      OP_AND:  s = {1'b0, a & b};
      OP_OR:   s = {1'b0, a | b};
      OP_XOR:  s = {1'b0, a ^ b};
      OP_SLT:  s = {4'b0, ($signed(a) < $signed(b))};
      default: s = {4'b0, (a == b)};
    endcase
    return {s[3:0], c, (s[3:0] == 4'd0), v};
  endfunction

  always_comb {alu_out, alu_carry, alu_zero, alu_ovf} = alu_ref(alu_a, alu_b, alu_op);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: response queue, one in-flight op, accumulator and counter
  logic [6:0]       m_q[$];
  bit               m_busy = 0;
  logic [6:0]       m_pend = '0;
  logic [3:0]       m_acc = '0;
  logic [CNT_W-1:0] m_cnt = '0;
  int               m_total = 0;
  bit               m_known = 0;

  task automatic cycle(input logic rn, input logic v, input logic [2:0] op,
                       input logic [3:0] a, input logic [3:0] b, input logic ua,
                       input logic rr);
    bit hs;
    bit pop;
    if (m_known) begin
      check_eq("req_ready", 32'(bus.req_ready),
               32'(rst_n && !m_busy && (m_q.size() < RSP_DEPTH)));
      check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        check_eq("rsp_data", 32'(bus.rsp_data), 32'(m_q[0][6:3]));
        check_eq("rsp_flags", 32'(bus.rsp_flags), 32'(m_q[0][2:0]));
      end
      check_eq("acc", 32'(acc), 32'(m_acc));
      check_eq("op_count", 32'(op_count), 32'(m_cnt));
    end
    rst_n           = rn;
    bus.req_valid   = v;
    bus.req_op      = op;
    bus.req_a       = a;
    bus.req_b       = b;
    bus.req_use_acc = ua;
    bus.rsp_ready   = rr;
    hs  = v && rn && !m_busy && (m_q.size() < RSP_DEPTH);
    pop = rr && (m_q.size() != 0);
    @(posedge clk);
    if (!rn) begin
      m_q.delete();
      m_busy  = 0;
      m_acc   = '0;
      m_cnt   = '0;
      m_total = 0;
      m_known = 1;
    end else if (m_known) begin
      if (pop) void'(m_q.pop_front());
      if (m_busy) begin
        m_q.push_back(m_pend);
        m_acc = m_pend[6:3];
        m_cnt = m_cnt + 1'b1;
        m_total++;
        m_busy = 0;
      end else if (hs) begin
        m_pend = alu_ref(ua ? m_acc : a, b, op);
        m_busy = 1;
      end
    end
    #1;
  endtask

  task automatic idle(input logic rr);
    cycle(1'b1, 1'b0, OP_ADD, 4'd0, 4'd0, 1'b0, rr);
  endtask

  task automatic rand_cycle(input int pv, input int pr, input int prst);
    cycle(($urandom_range(0, 99) >= prst), ($urandom_range(0, 99) < pv),
          3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 99) < pr));
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_op      = '0;
    bus.req_a       = '0;
    bus.req_b       = '0;
    bus.req_use_acc = 1'b0;
    bus.rsp_ready   = 1'b0;

    repeat (3) cycle(1'b0, 1'b1, OP_ADD, 4'd1, 4'd1, 1'b0, 1'b0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check_eq("rst_acc", 32'(acc), 32'd0);
    check_eq("rst_op_count", 32'(op_count), 32'd0);
    idle(1'b0);
    check_eq("ready_after_rst", 32'(bus.req_ready), 32'd1);

    cycle(1'b1, 1'b1, OP_ADD, 4'd9, 4'd8, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("add_data", 32'(bus.rsp_data), 32'd1);
    check_eq("add_flags", 32'(bus.rsp_flags), 32'b101);
    check_eq("add_acc", 32'(acc), 32'd1);
    check_eq("add_count", 32'(op_count), 32'd1);
    idle(1'b1);

    cycle(1'b1, 1'b1, OP_SUB, 4'd3, 4'd3, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("sub_data", 32'(bus.rsp_data), 32'd0);
    check_eq("sub_flags", 32'(bus.rsp_flags), 32'b010);
    cycle(1'b1, 1'b1, OP_NOTA, 4'd5, 4'd0, 1'b1, 1'b1);
    idle(1'b0);
    check_eq("chain_data", 32'(bus.rsp_data), 32'hF);
    idle(1'b1);

    for (int i = 0; i < 6; i++)
      cycle(1'b1, 1'b1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'b0, 1'b0);
    check_eq("bp_full_ready", 32'(bus.req_ready), 32'd0);
    check_eq("bp_full_valid", 32'(bus.rsp_valid), 32'd1);
    cycle(1'b1, 1'b1, OP_XOR, 4'd6, 4'd3, 1'b0, 1'b1);
    check_eq("bp_ready_after_pop", 32'(bus.req_ready), 32'd1);
    cycle(1'b1, 1'b1, OP_OR, 4'd8, 4'd1, 1'b0, 1'b0);
    repeat (6) idle(1'b1);

    cycle(1'b1, 1'b1, OP_ADD, 4'd2, 4'd2, 1'b0, 1'b0);
    idle(1'b0);
    cycle(1'b1, 1'b1, OP_XOR, 4'd5, 4'd3, 1'b0, 1'b0);
    idle(1'b1);
    check_eq("pushpop_valid", 32'(bus.rsp_valid), 32'd1);
    check_eq("pushpop_data", 32'(bus.rsp_data), 32'd6);
    repeat (3) idle(1'b1);

    cycle(1'b1, 1'b1, OP_ADD, 4'd1, 4'd1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, OP_ADD, 4'd0, 4'd0, 1'b0, 1'b0);
    check_eq("midrst_count", 32'(op_count), 32'd0);
    check_eq("midrst_acc", 32'(acc), 32'd0);
    check_eq("midrst_valid", 32'(bus.rsp_valid), 32'd0);

    for (int i = 0; i < 2000 && m_total < 256; i++)
      cycle(1'b1, 1'b1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
    check_eq("wrap_ops", 32'(m_total), 32'd256);
    check_eq("wrap_count", 32'(op_count), 32'd0);

    for (int i = 0; i < 1500; i++) rand_cycle(70, 50, 1);
    repeat (6) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issuer.md
# alu_issuer

Sequential initiator for the 4-bit combinational ALU. It accepts operation requests over a valid/ready handshake and drives operands and opcode onto the ALU's A/B/btn inputs. It then captures the ALU's out/Carry/Zero/Overflow into a 2-entry response FIFO and returns them over a second valid/ready handshake. A 4-bit accumulator lets a request take the previous result as operand A, so software-style op chains run without round trips.

## Interface
- RSP_DEPTH, 2: response FIFO depth (power of two, ≥2).
- CNT_W, 8: width of the completed-operation counter.

- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&ready at an edge.
- req_op  in  3  ALU opcode: 000 add, 001 sub, 010 notA, 011 and, 100 or, 101 xor, 110 slt, 111 eq.
- req_a  in  4  operand A (ignored when req_use_acc=1).
- req_b  in  4  operand B.
- req_use_acc  in  1  1: A = accumulator.
- alu_a  out  4  to ALU A.
- alu_b  out  4  to ALU B.
- alu_op  out  3  to ALU btn.
- alu_out  in  4  ALU out.
- alu_carry  in  1  ALU Carry.
- alu_zero  in  1  ALU Zero.
- alu_ovf  in  1  ALU Overflow.
- rsp_valid  out  1  FIFO non-empty.
- rsp_ready  in  1  consumer pop.
- rsp_data  out  4  head result.
- rsp_flags  out  3  head {carry, zero, ovf}.
- acc  out  4  accumulator value.
- op_count  out  CNT_W  completed operations, wraps.

## Operation
- FSM states: IDLE, ISSUE.
- IDLE: req_ready = (fifo_count + 0 < RSP_DEPTH). On handshake, latch operands into the alu_a/alu_b/alu_op registers, with A taken from acc if req_use_acc=1. Then go to ISSUE.
- ISSUE: ALU inputs are stable from registers for the whole cycle. At the closing edge:
  - push {alu_out, alu_carry, alu_zero, alu_ovf} into the FIFO;
  - acc ← alu_out;
  - op_count ← op_count+1, mod 2^CNT_W;
  - return to IDLE.
- FIFO space is guaranteed at ISSUE, because req_ready already required a free slot. An overflow push never occurs.
- FIFO: rsp_valid = count≠0; pop on rsp_valid&rsp_ready. Push and pop may occur in the same edge; count is then unchanged. Pointers wrap modulo RSP_DEPTH.
- req_ready is low in ISSUE. Maximum throughput is one op per 2 cycles.
- Flags are passed through from the ALU unmodified. The issuer does no arithmetic of its own.
- Reset (any cycle, including mid-ISSUE): state=IDLE; FIFO emptied; any in-flight op is discarded and not counted.
- Reset values: alu_a=0, alu_b=0, alu_op=000, acc=0, op_count=0, rsp_valid=0, rsp_data=0, rsp_flags=0, req_ready=0 during reset and 1 on the first cycle after.

## Timing
- Request accepted at edge E. The ALU sees the new operands during cycle E→E+1. The response is pushed at E+1, and rsp_valid is high from E+1 (cycle after) if the FIFO was empty.
- Request-to-response latency: 2 edges. Response data is registered, not combinational from the ALU.
- rsp_data/rsp_flags are held stable while rsp_valid=1 and rsp_ready=0.
- req_use_acc sees the accumulator as of the acceptance edge. Back-to-back chained ops therefore see the immediately previous result.
- No combinational path from req_valid to req_ready, or from rsp_ready to rsp_valid.

## Structure
- Shared package `alu_pkg`: opcode localparams (OP_ADD…OP_EQ), flag bit indices (FLG_C=2, FLG_Z=1, FLG_V=0), FSM state encoding.
- One sub-module: `rsp_fifo` (parameterised width 7, depth RSP_DEPTH, synchronous active-low reset, count output).
- The ALU is instantiated in the bench and not inside this block.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 → req_ready=0, rsp_valid=0, acc=0, op_count=0. On the first cycle after release, req_ready=1.
- Add with carry: A=9, B=8, op=000 → two edges later rsp_data=1, flags={1,0,1}, acc=1, op_count=1.
- Chain: sub A=3,B=3 (rsp 0, Z=1), then use_acc=1 op=010 B=0 → rsp_data=F. The accumulator is used, not req_a.
- Backpressure: rsp_ready=0, issue 3 requests → first two accepted; req_ready stays 0 on the third until one pop. The FIFO order is preserved.
- Simultaneous push/pop: FIFO holding 1 entry, rsp_ready=1 while ISSUE completes → count stays 1. The popped head is the old entry, and the new one follows next cycle.
- Reset mid-ISSUE: assert rst_n=0 in the ISSUE cycle → no push, op_count=0, acc=0. Then a wrap test: run 256 ops with CNT_W=8 → op_count returns to 0.
